// File: rtl/dcache_resp.sv
// Data-side memory responder: serializes LSB load/store requests into byte accesses on the shared RAM port.
// Latency: load done at grant+len+1, store done at grant+len (plus cycles without grant, IO stalls, en=0).
// Backpressure: holds on mem_gnt_i low, iob_full_i high (IO stores) and en low; optional DC_PERF_CNT_EN adds counters.

`ifndef DAT_W
`define DAT_W 32
`endif
`ifndef OP_W
`define OP_W 4
`endif
`ifndef LB
`define LB  4'd0
`define LH  4'd1
`define LW  4'd2
`define LBU 4'd4
`define LHU 4'd5
`define SB  4'd8
`define SH  4'd9
`define SW  4'd10
`endif

module dcache_resp #(
    parameter logic [`DAT_W-1:0] IO_BASE = 32'h0003_0000,
    parameter int                PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              lsb_en_i,
    input  logic              lsb_rwen_i,
    input  logic [`OP_W-1:0]  lsb_op_i,
    input  logic [2:0]        lsb_len_i,
    input  logic [`DAT_W-1:0] lsb_adr_i,
    input  logic [`DAT_W-1:0] lsb_dat_i,
    output logic              lsb_en_o,
    output logic [`DAT_W-1:0] lsb_dat_o,
    input  logic              br_flag,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [`DAT_W-1:0] mem_a_o,
    output logic [7:0]        mem_dout_o,
    output logic              mem_wr_o,
    input  logic [7:0]        mem_din_i,
    input  logic              iob_full_i,
    output logic [PERF_W-1:0] perf_ld_o,
    output logic [PERF_W-1:0] perf_st_o,
    output logic [PERF_W-1:0] perf_stall_o
);

    localparam int DW = `DAT_W;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_GNT, S_RD, S_WR, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [`OP_W-1:0]  r_op;
    logic              r_store;
    logic [2:0]        r_len;
    logic [DW-1:0]     r_adr, r_dat, r_buf, r_dat_o;
    logic [2:0]        r_cnt;
    logic              r_cap_vld;
    logic [1:0]        r_cap_idx;

    logic              w_busy, w_io_blk, w_abort, w_issue, w_last_issue;
    logic              w_cap, w_cap_last, w_accept, w_done_pulse;
    logic [2:0]        w_len_in;
    logic [DW-1:0]     w_raw, w_ext;

    assign w_len_in     = (lsb_len_i == 3'd1) ? 3'd1 : (lsb_len_i == 3'd2) ? 3'd2 : 3'd4;
    assign w_busy       = (r_state == S_WAIT_GNT) || (r_state == S_RD) || (r_state == S_WR);
    assign w_io_blk     = r_store && (r_adr >= IO_BASE) && iob_full_i;
    // Only loads may be flushed; stores must complete because the LSB has already retired them.
    assign w_abort      = br_flag && !r_store && ((r_state == S_WAIT_GNT) || (r_state == S_RD));
    assign w_issue      = en && w_busy && mem_gnt_i && (r_cnt < r_len) && !w_io_blk && !w_abort;
    assign w_last_issue = w_issue && (r_cnt == r_len - 3'd1);
    // Read capture is independent of grant: the address already went out the cycle before.
    assign w_cap        = en && r_cap_vld;
    assign w_cap_last   = w_cap && ({1'b0, r_cap_idx} == r_len - 3'd1);
    assign w_accept     = en && (r_state == S_IDLE) && lsb_en_i && !br_flag;
    // Pulse gated by en so a frozen DONE cycle is reported once, when the pipeline moves again.
    assign w_done_pulse = en && (r_state == S_DONE) && !(br_flag && !r_store);

    // Merge the incoming RAM byte into the assembly buffer at its little-endian lane.
    always_comb begin
        w_raw = r_buf;
        w_raw[{r_cap_idx, 3'b000} +: 8] = mem_din_i;
    end

    // Sign/zero extension of the assembled load data by opcode.
    always_comb begin
        case (r_op)
            `LB:     w_ext = {{(DW-8){w_raw[7]}}, w_raw[7:0]};
            `LBU:    w_ext = {{(DW-8){1'b0}}, w_raw[7:0]};
            `LH:     w_ext = {{(DW-16){w_raw[15]}}, w_raw[15:0]};
            `LHU:    w_ext = {{(DW-16){1'b0}}, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and memory-port outputs.
    always_comb begin
        w_next     = r_state;
        mem_req_o  = w_busy;
        mem_wr_o   = w_issue && r_store;
        mem_dout_o = 8'h00;
        mem_a_o    = '0;
        lsb_en_o   = w_done_pulse;
        if (w_issue && r_store)
            mem_dout_o = r_dat[{r_cnt[1:0], 3'b000} +: 8];
        // While frozen with a read capture pending, repeat its address so the byte is re-sampled on resume.
        if (w_busy)
            mem_a_o = (!en && r_cap_vld) ? r_adr + DW'(r_cap_idx) : r_adr + DW'(r_cnt);
        if (en) begin
            case (r_state)
                S_IDLE:     if (lsb_en_i && !br_flag) w_next = S_WAIT_GNT;
                S_WAIT_GNT: begin
                    if (w_abort)           w_next = S_IDLE;
                    else if (mem_gnt_i) begin
                        if (!r_store)          w_next = S_RD;
                        else if (w_last_issue) w_next = S_DONE;
                        else                   w_next = S_WR;
                    end
                end
                S_RD:       if (w_abort) w_next = S_IDLE; else if (w_cap_last) w_next = S_DONE;
                S_WR:       if (w_last_issue) w_next = S_DONE;
                S_DONE:     w_next = S_IDLE;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    // Request latch, byte counter, read capture and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_store   <= 1'b0;
            r_len     <= 3'd0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_buf     <= '0;
            r_dat_o   <= '0;
            r_cnt     <= 3'd0;
            r_cap_vld <= 1'b0;
            r_cap_idx <= 2'd0;
        end else if (w_accept) begin
            r_op      <= lsb_op_i;
            r_store   <= lsb_rwen_i;
            r_len     <= w_len_in;
            r_adr     <= lsb_adr_i;
            r_dat     <= lsb_dat_i;
            r_buf     <= '0;
            r_cnt     <= 3'd0;
            r_cap_vld <= 1'b0;
        end else if (en) begin
            if (w_issue) r_cnt <= r_cnt + 3'd1;
            r_cap_vld <= w_issue && !r_store;
            r_cap_idx <= r_cnt[1:0];
            if (w_cap) r_buf <= w_raw;
            if (w_cap_last && !w_abort)      r_dat_o <= w_ext;
            else if (w_last_issue && r_store) r_dat_o <= '0;
        end
    end

    assign lsb_dat_o = r_dat_o;

`ifdef DC_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_ld, r_perf_st, r_perf_stall;
    logic              w_stall;

    // A stall is a cycle waiting for grant or a granted IO store blocked by a full IO buffer.
    assign w_stall = en && (((r_state == S_WAIT_GNT) && !mem_gnt_i) ||
                            (w_busy && mem_gnt_i && (r_cnt < r_len) && w_io_blk));

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_ld    <= '0;
            r_perf_st    <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_done_pulse && !r_store) r_perf_ld <= r_perf_ld + 1'b1;
            if (w_done_pulse && r_store)  r_perf_st <= r_perf_st + 1'b1;
            if (w_stall)                  r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_ld_o    = r_perf_ld;
    assign perf_st_o    = r_perf_st;
    assign perf_stall_o = r_perf_stall;
`else
    assign perf_ld_o    = '0;
    assign perf_st_o    = '0;
    assign perf_stall_o = '0;
`endif

endmodule
